// File: rtl/ads1672_acq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ads1672_acq_ctrl
// Purpose  : ADS1672 burst acquisition sequencer (arm/trigger/settle/capture)
// Revision : 1.0
// ============================================================================
module ads1672_acq_ctrl #(
    parameter int COUNT          = 8,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int IDX_W          = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             trig,
    input  logic             abort,
    input  logic             adc_drdy_n,
    output logic             adc_start,
    output logic             cap_strobe,
    output logic [IDX_W-1:0] cap_idx,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam int c_SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int c_TMO_W    = $clog2(TIMEOUT_CYCLES);

    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LOAD = c_SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [c_TMO_W-1:0]    c_TMO_LAST    = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]      c_LAST_IDX    = IDX_W'(COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_SETTLE = 3'd2,
        S_ACQ    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                r_state;
    logic [c_SETTLE_W-1:0] r_settle_cnt;
    logic [c_TMO_W-1:0]    r_tmo_cnt;
    logic [IDX_W-1:0]      r_sample_cnt;
    logic                  r_drdy_prev;
    logic                  w_fall;

    // Falling edge of the already-synchronised DRDY line.
    assign w_fall = r_drdy_prev & ~adc_drdy_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_sample_cnt <= '0;
            r_drdy_prev  <= 1'b1;
            adc_start    <= 1'b0;
            cap_strobe   <= 1'b0;
            cap_idx      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            r_drdy_prev <= adc_drdy_n;
            cap_strobe  <= 1'b0;
            done        <= 1'b0;

            if (r_state != S_IDLE && abort) begin
                r_state   <= S_IDLE;
                adc_start <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (arm) begin
                            r_state     <= S_ARMED;
                            busy        <= 1'b1;
                            timeout_err <= 1'b0;
                        end
                    end
                    S_ARMED: begin
                        if (trig) begin
                            r_state      <= S_SETTLE;
                            adc_start    <= 1'b1;
                            r_settle_cnt <= c_SETTLE_LOAD;
                        end
                    end
                    S_SETTLE: begin
                        if (r_settle_cnt == '0) begin
                            r_state      <= S_ACQ;
                            r_sample_cnt <= '0;
                            r_tmo_cnt    <= '0;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - c_SETTLE_W'(1);
                        end
                    end
                    S_ACQ: begin
                        if (w_fall) begin
                            cap_strobe <= 1'b1;
                            cap_idx    <= r_sample_cnt;
                            r_tmo_cnt  <= '0;
                            // Last sample leaves the counter at COUNT-1; it never wraps.
                            if (r_sample_cnt == c_LAST_IDX) begin
                                r_state   <= S_DONE;
                                done      <= 1'b1;
                                adc_start <= 1'b0;
                            end else begin
                                r_sample_cnt <= r_sample_cnt + IDX_W'(1);
                            end
                        end else if (r_tmo_cnt == c_TMO_LAST) begin
                            r_state     <= S_IDLE;
                            adc_start   <= 1'b0;
                            busy        <= 1'b0;
                            timeout_err <= 1'b1;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        adc_start <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ads1672_acq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ads1672_acq_ctrl
// Purpose  : Directed vector bench for ads1672_acq_ctrl (COUNT=4 and COUNT=1)
// Revision : 1.0
// ============================================================================
module tb_ads1672_acq_ctrl;

    typedef struct {
        int   n;
        logic arm, trig, abort, drdy;
        logic start, strobe;
        int   idx;
        logic busy, done, err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       arm_a, trig_a, abort_a, drdy_a;
    logic       start_a, strobe_a, busy_a, done_a, err_a;
    logic [1:0] idx_a;
    logic       arm_b, trig_b, abort_b, drdy_b;
    logic       start_b, strobe_b, busy_b, done_b, err_b;
    logic [0:0] idx_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    ads1672_acq_ctrl #(.COUNT(4), .SETTLE_CYCLES(3), .TIMEOUT_CYCLES(16)) u_dut_a (
        .clk(clk), .rst(rst), .arm(arm_a), .trig(trig_a), .abort(abort_a),
        .adc_drdy_n(drdy_a), .adc_start(start_a), .cap_strobe(strobe_a),
        .cap_idx(idx_a), .busy(busy_a), .done(done_a), .timeout_err(err_a)
    );

    ads1672_acq_ctrl #(.COUNT(1), .SETTLE_CYCLES(3), .TIMEOUT_CYCLES(16)) u_dut_b (
        .clk(clk), .rst(rst), .arm(arm_b), .trig(trig_b), .abort(abort_b),
        .adc_drdy_n(drdy_b), .adc_start(start_b), .cap_strobe(strobe_b),
        .cap_idx(idx_b), .busy(busy_b), .done(done_b), .timeout_err(err_b)
    );

    function automatic vec_t mk(input int n, input logic arm, input logic trig,
                                input logic abort, input logic drdy,
                                input logic start, input logic strobe, input int idx,
                                input logic busy, input logic done, input logic err);
        vec_t v;
        v.n = n; v.arm = arm; v.trig = trig; v.abort = abort; v.drdy = drdy;
        v.start = start; v.strobe = strobe; v.idx = idx;
        v.busy = busy; v.done = done; v.err = err;
        return v;
    endfunction

    task automatic check(input int sel, input vec_t e, input string tag);
        logic [4:0] act;
        logic [4:0] exp;
        logic [7:0] aidx;
        if (sel == 0) begin
            act  = {start_a, strobe_a, busy_a, done_a, err_a};
            aidx = 8'(idx_a);
        end else begin
            act  = {start_b, strobe_b, busy_b, done_b, err_b};
            aidx = 8'(idx_b);
        end
        exp = {e.start, e.strobe, e.busy, e.done, e.err};
        n_checks++;
        if (act !== exp || aidx !== 8'(e.idx)) begin
            n_fail++;
            $display("FAIL %s: start/strobe/busy/done/err=%b idx=%0d, required %b idx=%0d",
                     tag, act, aidx, exp, e.idx);
        end
    endtask

    task automatic drive(input int sel, input vec_t v);
        arm_a   = (sel == 0) ? v.arm   : 1'b0;
        trig_a  = (sel == 0) ? v.trig  : 1'b0;
        abort_a = (sel == 0) ? v.abort : 1'b0;
        drdy_a  = (sel == 0) ? v.drdy  : 1'b1;
        arm_b   = (sel == 1) ? v.arm   : 1'b0;
        trig_b  = (sel == 1) ? v.trig  : 1'b0;
        abort_b = (sel == 1) ? v.abort : 1'b0;
        drdy_b  = (sel == 1) ? v.drdy  : 1'b1;
    endtask

    // Each row holds its inputs for n cycles; outputs are checked 1 ns after every edge.
    task automatic run(input int sel, input string name);
        foreach (tbl[r]) begin
            for (int c = 0; c < tbl[r].n; c++) begin
                drive(sel, tbl[r]);
                @(posedge clk);
                #1;
                check(sel, tbl[r], $sformatf("%s row %0d cyc %0d", name, r, c));
            end
        end
        tbl.delete();
    endtask

    initial begin
        rst = 1'b0;
        drive(0, mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        #2;
        check(0, mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "reset a");
        check(1, mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "reset b");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // trig and DRDY in IDLE do nothing
        tbl.push_back(mk(2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        run(0, "gate");

        // nominal burst, DRDY edge landing on the last SETTLE edge is discarded
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(4, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(9, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(9, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 2, 1, 0, 0));
        tbl.push_back(mk(9, 0, 0, 0, 1, 1, 0, 2, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0));
        run(0, "nominal");

        // timeout 16 cycles after the second edge, then arm clears the flag
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 3, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 3, 1, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0, 1, 1, 0, 3, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 3, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(15, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(2, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        run(0, "timeout");

        // abort coincident with the third edge
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(2, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(2, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        run(0, "abort");

        // asynchronous reset in ACQ, between clock edges
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0));
        run(0, "pre-reset");
        #3;
        rst = 1'b0;
        #1;
        check(0, mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "async reset");
        @(negedge clk);
        rst = 1'b1;
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        run(0, "post-reset");

        // COUNT=1: single edge gives strobe+done, arm in DONE ignored, rearm in IDLE
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        run(1, "count1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
